// File: rtl/fifo_rr_scheduler_pkg.sv
// Shared definitions for the round-robin FIFO read scheduler: FSM state
// encodings and a onehot-to-index helper.
package fifo_rr_scheduler_pkg;

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Index of the highest set bit; returns 0 for an all-zero vector.
    function automatic int onehot_to_idx(input logic [63:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 64; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first requester strictly after Ptr,
// wrapping modulo NREQ, so the source at Ptr has the lowest priority.
module rr_pick
    import fifo_rr_scheduler_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int SW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] Req,
    input  logic [SW-1:0]   Ptr,
    output logic [NREQ-1:0] Gnt,
    output logic [SW-1:0]   GntIdx,
    output logic            Any
);

    always_comb begin
        logic found;
        int   idx;
        Gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(Ptr) + k) % NREQ;
            if (!found && Req[idx]) begin
                Gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign Any    = |Req;
    assign GntIdx = SW'(onehot_to_idx(64'(Gnt)));

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Round-robin read scheduler for NREQ single-word FIFOs with bounded bursts,
// per-source enables and a one-entry Valid/Ready output slot.
module fifo_rr_scheduler
    import fifo_rr_scheduler_pkg::*;
#(
    parameter int DW    = 32,
    parameter int NREQ  = 4,
    parameter int BURST = 2,
    localparam int SW   = $clog2(NREQ)
) (
    input  logic               Clk,
    input  logic               ARstN,
    input  logic [NREQ-1:0]    FifoEty,
    input  logic [NREQ*DW-1:0] FifoData,
    output logic [NREQ-1:0]    FifoRd,
    input  logic [NREQ-1:0]    SrcEn,
    output logic [DW-1:0]      OutData,
    output logic [SW-1:0]      OutSrc,
    output logic               OutValid,
    input  logic               OutReady,
    output logic               UnfErr
);

    // state   | meaning
    // ST_ARB  | pick the next requester after Ptr when the slot can take a word
    // ST_HOLD | keep popping source Ptr until BURST words or it stops requesting

    localparam int BW = $clog2(BURST + 1);

    logic [0:0]      state;
    logic [SW-1:0]   ptr;
    logic [BW-1:0]   burst_cnt;
    logic [NREQ-1:0] req;
    logic            slot_free;
    logic [NREQ-1:0] gnt;
    logic [SW-1:0]   gnt_idx;
    logic            any;
    logic            hold_go;
    logic            arb_mode;
    logic            pop;
    logic [SW-1:0]   pop_idx;
    logic [NREQ-1:0] rd_vec;

    assign req       = ~FifoEty & SrcEn;
    assign slot_free = ~OutValid | OutReady;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .Req    (req),
        .Ptr    (ptr),
        .Gnt    (gnt),
        .GntIdx (gnt_idx),
        .Any    (any)
    );

    // A HOLD source that stops requesting falls through to arbitration in the
    // same cycle, so there is no bubble between bursts.
    assign hold_go  = (state == ST_HOLD) && req[ptr] && slot_free;
    assign arb_mode = (state == ST_ARB) || !req[ptr];
    assign pop      = hold_go || (arb_mode && slot_free && any);
    assign pop_idx  = hold_go ? ptr : gnt_idx;
    assign rd_vec   = hold_go ? (NREQ'(1) << ptr) : gnt;
    assign FifoRd   = (pop && ARstN) ? rd_vec : '0;

    always_ff @(posedge Clk or negedge ARstN) begin
        if (!ARstN) begin
            state     <= ST_ARB;
            ptr       <= SW'(NREQ - 1);
            burst_cnt <= '0;
        end else if (hold_go) begin
            burst_cnt <= burst_cnt + 1'b1;
            state     <= (burst_cnt == BW'(BURST - 1)) ? ST_ARB : ST_HOLD;
        end else if (arb_mode && pop) begin
            ptr       <= gnt_idx;
            burst_cnt <= BW'(1);
            state     <= (BURST > 1) ? ST_HOLD : ST_ARB;
        end else if (arb_mode) begin
            state     <= ST_ARB;
        end
    end

    always_ff @(posedge Clk or negedge ARstN) begin
        if (!ARstN) begin
            OutData  <= '0;
            OutSrc   <= '0;
            OutValid <= 1'b0;
        end else if (pop) begin
            OutData  <= FifoData[int'(pop_idx)*DW +: DW];
            OutSrc   <= pop_idx;
            OutValid <= 1'b1;
        end else if (OutValid && OutReady) begin
            OutValid <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge ARstN) begin
        if (!ARstN) begin
            UnfErr <= 1'b0;
        end else if (|(FifoRd & FifoEty)) begin
            UnfErr <= 1'b1;
        end
    end

endmodule
